mem_access_ctrl: RTL

- Initiator side of the byte-addressed data-memory interface used by the CPU datapath.
- Accepts one load/store request per handshake from the CPU.
- Serialises each request into byte-wide bus cycles toward the byte-organised data RAM, big-endian: the byte at the base address holds bits 31:24.
- Assembles read bytes into a 32-bit result and returns it with a one-cycle response strobe.

---
 rtl/mem_access_pkg.sv | 16 +
 rtl/mem_load_align.sv | 31 +++
 rtl/mem_access_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the data-memory access controller:
// FSM state encoding, bus direction constants and the word size.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/mem_load_align.sv
// Load-result formatting for the memory access controller.
// Takes the assembled read bytes (byte loads use only bits 7:0).
// Produces the value returned to the CPU: the full word, or a sign/zero-extended byte.
// Stores always return zero.
module mem_load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] bytes_in,
    input  logic        is_byte,
    input  logic        is_signed,
    input  logic        is_write,
    output logic [31:0] rdata
);

    // Pick word or extended byte; stores carry no read data
    always_comb begin
        rdata = '0;
        if (is_write != MEM_WRITE) begin
            if (is_byte) begin
                if (is_signed) begin
                    rdata = {{24{bytes_in[7]}}, bytes_in[7:0]};
                end else begin
                    rdata = {24'h0, bytes_in[7:0]};
                end
            end else begin
                rdata = bytes_in;
            end
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// CPU-side initiator for the byte-organised data RAM.
// Each load/store is turned into 1 or 4 byte-wide bus cycles, big-endian (base byte = bits 31:24).
// A one-cycle response strobe follows the bus cycles.
// Optional build macro MEM_ACCESS_ALIGN_CHECK_EN: misaligned word requests are
// rejected with rsp_err instead of being transferred.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int WORD_BYTES = mem_access_pkg::WORD_BYTES
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic              mem_RW,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wbyte,
    input  logic [7:0]        mem_rbyte
);

    localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] last_idx;
    logic [23:0]      wdata_q;
    logic             write_q;
    logic             byte_q;
    logic             signed_q;
    logic [23:0]      asm_q;
    logic [31:0]      asm_next;
    logic [31:0]      aligned;

    // The byte arriving this cycle is shifted in, so the last one is included in the response.
    assign asm_next = {asm_q, mem_rbyte};

    mem_load_align u_align (
        .bytes_in  (asm_next),
        .is_byte   (byte_q),
        .is_signed (signed_q),
        .is_write  (write_q),
        .rdata     (aligned)
    );

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    logic err_q;
    logic misaligned;
    assign misaligned = !req_byte && (req_addr[1:0] != 2'b00);
    assign rsp_err    = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // Request FSM: accept in IDLE, walk the bytes in XFER, strobe the result in RESP
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            last_idx  <= '0;
            wdata_q   <= '0;
            write_q   <= MEM_READ;
            byte_q    <= 1'b0;
            signed_q  <= 1'b0;
            asm_q     <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            mem_en    <= 1'b0;
            mem_RW    <= MEM_READ;
            mem_addr  <= '0;
            mem_wbyte <= '0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        write_q   <= req_write;
                        byte_q    <= req_byte;
                        signed_q  <= req_signed;
                        wdata_q   <= req_wdata[23:0];
                        asm_q     <= '0;
                        idx       <= '0;
                        last_idx  <= req_byte ? '0 : IDX_W'(WORD_BYTES - 1);
                        req_ready <= 1'b0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
                        if (misaligned) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= '0;
                            err_q     <= 1'b1;
                        end else begin
                            state     <= XFER;
                            mem_en    <= 1'b1;
                            mem_RW    <= req_write;
                            mem_addr  <= req_addr;
                            mem_wbyte <= req_byte ? req_wdata[7:0] : req_wdata[31:24];
                        end
`else
                        state     <= XFER;
                        mem_en    <= 1'b1;
                        mem_RW    <= req_write;
                        mem_addr  <= req_addr;
                        mem_wbyte <= req_byte ? req_wdata[7:0] : req_wdata[31:24];
`endif
                    end
                end
                XFER: begin
                    asm_q <= asm_next[23:0];
                    if (idx == last_idx) begin
                        state     <= RESP;
                        mem_en    <= 1'b0;
                        mem_RW    <= MEM_READ;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= aligned;
                    end else begin
                        idx       <= idx + IDX_W'(1);
                        mem_addr  <= mem_addr + ADDR_W'(1);
                        mem_wbyte <= wdata_q[23:16];
                        wdata_q   <= {wdata_q[15:0], 8'h00};
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
                    err_q     <= 1'b0;
`endif
                end
                default: begin
                    state     <= IDLE;
                    mem_en    <= 1'b0;
                    mem_RW    <= MEM_READ;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
